// File: rtl/condicionador_botoes.sv
// Button conditioner for the memory game: synchronises, debounces press and release,
// rejects multi-button presses and emits one tem_jogada pulse per valid press.
module condicionador_botoes #(
  parameter int N_BOTOES = 4,
  parameter int DEBOUNCE = 20,
  parameter int CONT_W   = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] jogada,
  output logic                tem_jogada,
  output logic                jogada_invalida,
  output logic [2:0]          db_estado
);

  typedef enum logic [2:0] {
    ESPERA     = 3'd0,
    ESTABILIZA = 3'd1,
    VALIDA     = 3'd2,
    SEGURA     = 3'd3,
    SOLTA      = 3'd4
  } estado_t;

  localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(DEBOUNCE - 1);

  estado_t             estado_reg, estado_next;
  logic [N_BOTOES-1:0] sync1_reg, sync2_reg;
  logic [N_BOTOES-1:0] amostra_reg, amostra_next;
  logic [CONT_W-1:0]   cont_reg, cont_next;
  logic [N_BOTOES-1:0] jogada_reg, jogada_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_reg  <= ESPERA;
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      amostra_reg <= '0;
      cont_reg    <= '0;
      jogada_reg  <= '0;
    end else begin
      estado_reg  <= estado_next;
      sync1_reg   <= botoes;
      sync2_reg   <= sync1_reg;
      amostra_reg <= amostra_next;
      cont_reg    <= cont_next;
      jogada_reg  <= jogada_next;
    end
  end

  always_comb begin
    estado_next  = estado_reg;
    amostra_next = amostra_reg;
    cont_next    = cont_reg;
    jogada_next  = jogada_reg;
    case (estado_reg)
      ESPERA: begin
        if (sync2_reg != '0) begin
          estado_next  = ESTABILIZA;
          amostra_next = sync2_reg;
          cont_next    = '0;
        end
      end
      ESTABILIZA: begin
        if (sync2_reg == '0) begin
          estado_next = ESPERA;
        end else if (sync2_reg != amostra_reg) begin
          amostra_next = sync2_reg;
          cont_next    = '0;
        end else if (cont_reg == CONT_MAX) begin
          estado_next = VALIDA;
          // Load the code on entry so jogada is already valid while tem_jogada is high.
          if ($onehot(amostra_reg)) jogada_next = amostra_reg;
        end else begin
          cont_next = cont_reg + CONT_W'(1);
        end
      end
      VALIDA: estado_next = SEGURA;
      SEGURA: begin
        if (sync2_reg == '0) begin
          estado_next = SOLTA;
          cont_next   = '0;
        end
      end
      SOLTA: begin
        if (sync2_reg != '0) begin
          estado_next = SEGURA;
        end else if (cont_reg == CONT_MAX) begin
          estado_next = ESPERA;
        end else begin
          cont_next = cont_reg + CONT_W'(1);
        end
      end
      default: estado_next = ESPERA;
    endcase
  end

  always_comb begin
    tem_jogada      = (estado_reg == VALIDA) &&  $onehot(amostra_reg);
    jogada_invalida = (estado_reg == VALIDA) && !$onehot(amostra_reg);
    db_estado       = estado_reg;
    jogada          = jogada_reg;
  end

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed bench for condicionador_botoes with DEBOUNCE=4; buttons driven on negedge.
module tb_condicionador_botoes;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  logic [3:0] jogada;
  logic       tem_jogada;
  logic       jogada_invalida;
  logic [2:0] db_estado;

  int tests = 0;
  int fails = 0;
  int n_tem = 0;
  int n_inv = 0;
  int n_both = 0;

  condicionador_botoes #(.N_BOTOES(4), .DEBOUNCE(4), .CONT_W(3)) dut (
    .clock(clock),
    .reset(reset),
    .botoes(botoes),
    .jogada(jogada),
    .tem_jogada(tem_jogada),
    .jogada_invalida(jogada_invalida),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Pulse counters sampled at posedge (pre-update values).
  always @(posedge clock) begin
    if (tem_jogada) n_tem <= n_tem + 1;
    if (jogada_invalida) n_inv <= n_inv + 1;
    if (tem_jogada && jogada_invalida) n_both <= n_both + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  int tem0, inv0;

  initial begin
    reset  = 1'b1;
    botoes = 4'b0000;
    wait_cycles(2);
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      check("idle_jogada", int'(jogada), 0);
      check("idle_tem", int'(tem_jogada), 0);
      check("idle_inv", int'(jogada_invalida), 0);
      check("idle_estado", int'(db_estado), 0);
      wait_cycles(1);
    end
    $display("[TB] step1 idle done");

    // 2: single valid press, exact latency
    botoes = 4'b0001;
    wait_cycles(6);
    check("p1_before_pulse", int'(tem_jogada), 0);
    check("p1_jogada_before", int'(jogada), 0);
    wait_cycles(1);
    check("p1_pulse", int'(tem_jogada), 1);
    check("p1_jogada", int'(jogada), 1);
    check("p1_valida", int'(db_estado), 2);
    wait_cycles(1);
    check("p1_pulse_end", int'(tem_jogada), 0);
    wait_cycles(2);
    check("p1_segura", int'(db_estado), 3);
    botoes = 4'b0000;
    wait_cycles(6);
    check("p1_solta", int'(db_estado), 4);
    wait_cycles(1);
    check("p1_espera", int'(db_estado), 0);
    check("p1_count", n_tem, 1);
    check("p1_jogada_held", int'(jogada), 1);
    $display("[TB] step2 press 0001 jogada=%b", jogada);

    // 3: bounce then stable press
    tem0 = n_tem;
    for (int i = 0; i < 6; i++) begin
      botoes = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      wait_cycles(1);
    end
    check("p3_no_pulse_bounce", n_tem, tem0);
    botoes = 4'b0100;
    wait_cycles(8);
    botoes = 4'b0000;
    wait_cycles(10);
    check("p3_count", n_tem, tem0 + 1);
    check("p3_jogada", int'(jogada), 4);
    check("p3_espera", int'(db_estado), 0);
    $display("[TB] step3 bounce press jogada=%b", jogada);

    // 4: two buttons -> invalid
    tem0 = n_tem;
    inv0 = n_inv;
    botoes = 4'b0011;
    wait_cycles(7);
    check("p4_inv_pulse", int'(jogada_invalida), 1);
    check("p4_tem_low", int'(tem_jogada), 0);
    wait_cycles(3);
    botoes = 4'b0000;
    wait_cycles(10);
    check("p4_inv_count", n_inv, inv0 + 1);
    check("p4_tem_count", n_tem, tem0);
    check("p4_jogada_kept", int'(jogada), 4);
    $display("[TB] step4 invalid 0011 jogada=%b", jogada);

    // 5: long hold
    tem0 = n_tem;
    botoes = 4'b1000;
    wait_cycles(3500);
    check("p5_segura", int'(db_estado), 3);
    check("p5_count", n_tem, tem0 + 1);
    check("p5_jogada", int'(jogada), 8);
    botoes = 4'b0000;
    wait_cycles(10);
    check("p5_espera", int'(db_estado), 0);
    check("p5_count_after", n_tem, tem0 + 1);
    $display("[TB] step5 long hold jogada=%b", jogada);

    // 6a: short glitch
    tem0 = n_tem;
    inv0 = n_inv;
    botoes = 4'b0010;
    wait_cycles(2);
    botoes = 4'b0000;
    wait_cycles(10);
    check("p6_glitch_tem", n_tem, tem0);
    check("p6_glitch_inv", n_inv, inv0);
    check("p6_glitch_espera", int'(db_estado), 0);
    $display("[TB] step6a glitch");

    // 6b: reset during ESTABILIZA
    botoes = 4'b0010;
    wait_cycles(3);
    check("p6_estabiliza", int'(db_estado), 1);
    reset  = 1'b1;
    botoes = 4'b0000;
    wait_cycles(1);
    check("p6_reset_estado", int'(db_estado), 0);
    check("p6_reset_jogada", int'(jogada), 0);
    reset = 1'b0;
    wait_cycles(10);
    check("p6_reset_no_tem", n_tem, tem0);
    check("p6_reset_espera", int'(db_estado), 0);
    check("never_both", n_both, 0);
    $display("[TB] step6b reset mid-press");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
